// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: control/branch/LUT-write inputs, ROM address/data and
// registered instruction outputs towards decode.
interface inst_fetch_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic         Start;
    logic         Stall;
    logic         BranchEn;
    logic [2:0]   TargetIdx;
    logic         LutWrEn;
    logic [2:0]   LutWrIdx;
    logic [A-1:0] LutWrData;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstIn;
    logic [W-1:0] Inst;
    logic         InstValid;
    logic         Done;

    modport master (
        output Start, Stall, BranchEn, TargetIdx,
        output LutWrEn, LutWrIdx, LutWrData, InstIn,
        input  InstAddress, Inst, InstValid, Done
    );

    modport slave (
        input  Start, Stall, BranchEn, TargetIdx,
        input  LutWrEn, LutWrIdx, LutWrData, InstIn,
        output InstAddress, Inst, InstValid, Done
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, 8-entry branch-target LUT, HALT_OP
// detection and stall/flush control with a registered instruction output.
module inst_fetch #(
    parameter int           A       = 10,
    parameter int           W       = 9,
    parameter logic [W-1:0] HALT_OP = 9'b111_111_111
) (
    input  logic          Clk,
    input  logic          ResetN,
    inst_fetch_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t       state;
    logic [A-1:0] pc;
    logic [W-1:0] inst_q;
    logic         valid_q;
    logic         done_q;
    logic [A-1:0] lut [8];

    assign bus.InstAddress = pc;
    assign bus.Inst        = inst_q;
    assign bus.InstValid   = valid_q;
    assign bus.Done        = done_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            pc      <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                lut[i] <= '0;
            end
        end else begin
            // Non-blocking write: a same-cycle branch reads the old entry.
            if (bus.LutWrEn) begin
                lut[bus.LutWrIdx] <= bus.LutWrData;
            end

            case (state)
                IDLE, HALT: begin
                    valid_q <= 1'b0;
                    if (bus.Start) begin
                        state  <= RUN;
                        pc     <= '0;
                        done_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!bus.Stall) begin
                        // Branch outranks halt: the fetched word is wrong-path.
                        if (bus.BranchEn) begin
                            pc      <= lut[bus.TargetIdx];
                            valid_q <= 1'b0;
                        end else if (bus.InstIn == HALT_OP) begin
                            state   <= HALT;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            inst_q  <= bus.InstIn;
                            valid_q <= 1'b1;
                            pc      <= pc + A'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
